// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: state numbers, opcodes
// and datapath mux/ALU select codes.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_JAL       = 4'd10,
    S_I_EXEC    = 4'd11,
    S_I_WB      = 4'd12,
    S_LUI_WB    = 4'd13,
    S_HALT      = 4'd14
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_LUI  = 6'b001111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_SLT   = 2'b11;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;
  localparam logic [1:0] M2R_LUI    = 2'b11;

endpackage

// File: rtl/multicycle_control_op_dispatch.sv
// Opcode dispatch out of DECODE: picks the first execution state for op and
// flags opcodes outside the supported set.
module mc_op_dispatch
  import multicycle_control_pkg::*;
#(
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  logic [5:0] op,
  output state_t     next_state,
  output logic       illegal
);

  always_comb begin
    illegal    = 1'b0;
    next_state = S_FETCH;
    case (op)
      OP_LW, OP_SW:     next_state = S_MEM_ADDR;
      OP_R:             next_state = S_R_EXEC;
      OP_BEQ, OP_BNE:   next_state = S_BRANCH;
      OP_J:             next_state = S_JUMP;
      OP_JAL:           next_state = S_JAL;
      OP_ADDI, OP_SLTI: next_state = S_I_EXEC;
      OP_LUI:           next_state = S_LUI_WB;
      default: begin
        illegal    = 1'b1;
        next_state = ILLEGAL_TRAP ? S_HALT : S_FETCH;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main controller (Moore FSM, outputs decoded from state).
// Optional macro MC_MEM_WAIT_EN adds mem_ready wait states on memory accesses.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
`ifdef MC_MEM_WAIT_EN
  input  logic       mem_ready,
`endif
  input  logic [5:0] op,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       PCWriteCondNe,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemToReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUop,
  output logic [1:0] PCSource,
  output logic       illegal,
  output logic [3:0] state
);

  state_t state_q;
  state_t decode_next;
  logic   decode_illegal;
  logic   ready;

`ifdef MC_MEM_WAIT_EN
  assign ready = mem_ready;
`else
  assign ready = 1'b1;
`endif

  mc_op_dispatch #(.ILLEGAL_TRAP(ILLEGAL_TRAP)) u_dispatch (
    .op         (op),
    .next_state (decode_next),
    .illegal    (decode_illegal)
  );

  // Memory-touching states only advance once the memory has answered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:     if (ready) state_q <= S_DECODE;
        S_DECODE:    state_q <= decode_next;
        S_MEM_ADDR:  state_q <= (op == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
        S_MEM_READ:  if (ready) state_q <= S_MEM_WB;
        S_MEM_WB:    state_q <= S_FETCH;
        S_MEM_WRITE: if (ready) state_q <= S_FETCH;
        S_R_EXEC:    state_q <= S_R_WB;
        S_R_WB:      state_q <= S_FETCH;
        S_BRANCH:    state_q <= S_FETCH;
        S_JUMP:      state_q <= S_FETCH;
        S_JAL:       state_q <= S_FETCH;
        S_I_EXEC:    state_q <= S_I_WB;
        S_I_WB:      state_q <= S_FETCH;
        S_LUI_WB:    state_q <= S_FETCH;
        S_HALT:      state_q <= S_HALT;
        default:     state_q <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    PCWrite       = 1'b0;
    PCWriteCond   = 1'b0;
    PCWriteCondNe = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    RegDst        = RD_RT;
    MemToReg      = M2R_ALUOUT;
    RegWrite      = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = SRCB_B;
    ALUop         = ALU_ADD;
    PCSource      = PCS_ALU;
    illegal       = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        IRWrite = ready;
        PCWrite = ready;
        ALUSrcB = SRCB_FOUR;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMM_SH;
        illegal = decode_illegal;
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemToReg = M2R_MDR;
      end
      S_MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_R_EXEC: begin
        ALUSrcA = 1'b1;
        ALUop   = ALU_FUNCT;
      end
      S_R_WB: begin
        RegWrite = 1'b1;
        RegDst   = RD_RD;
      end
      S_BRANCH: begin
        ALUSrcA       = 1'b1;
        ALUop         = ALU_SUB;
        PCSource      = PCS_ALUOUT;
        PCWriteCond   = (op == OP_BEQ);
        PCWriteCondNe = (op == OP_BNE);
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCS_JUMP;
      end
      // PC already holds PC+4 here, which is the link value for $31.
      S_JAL: begin
        PCWrite  = 1'b1;
        PCSource = PCS_JUMP;
        RegWrite = 1'b1;
        RegDst   = RD_RA;
        MemToReg = M2R_PC;
      end
      S_I_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUop   = (op == OP_SLTI) ? ALU_SLT : ALU_ADD;
      end
      S_I_WB: begin
        RegWrite = 1'b1;
      end
      S_LUI_WB: begin
        RegWrite = 1'b1;
        MemToReg = M2R_LUI;
      end
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle MIPS main controller; the sequential counterpart of the single-cycle opcode decoder.
- A Moore FSM that steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives the multi-cycle datapath: PC, IR, shared memory, register file, ALU muxes.
- Same opcode set: R-type, lw, sw, beq, bne, j, jal, addi, slti, lui.

Parameters:
ILLEGAL_TRAP, 0, 0: unknown opcode returns to FETCH; 1: enter HALT until reset

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
op  input  6  IR[31:26]; stable from the cycle after FETCH
PCWrite  output  1  unconditional PC load
PCWriteCond  output  1  PC load if ALU zero (beq)
PCWriteCondNe  output  1  PC load if ALU not zero (bne)
IorD  output  1  memory address: 0=PC, 1=ALUOut
MemRead  output  1  memory read strobe
MemWrite  output  1  memory write strobe
IRWrite  output  1  IR load
RegDst  output  2  00=rt, 01=rd, 10=$31
MemToReg  output  2  00=ALUOut, 01=MDR, 10=PC, 11={imm,16'b0}
RegWrite  output  1  register file write
ALUSrcA  output  1  0=PC, 1=A
ALUSrcB  output  2  00=B, 01=4, 10=sext imm, 11=sext imm<<2
ALUop  output  2  00=add, 01=sub, 10=funct, 11=slt
PCSource  output  2  00=ALU result, 01=ALUOut, 10=jump target
illegal  output  1  one-cycle pulse in DECODE on unknown opcode
state  output  4  current state, for debug/bench

Behaviour:
- State register only. All outputs are a combinational function of the state (plus op in BRANCH and I_EXEC). Unlisted outputs are 0.
- rst=1 at a clk edge puts the FSM in FETCH, from any state. Reset during rst: the FETCH outputs are visible, so the datapath must hold PC in reset itself. The bench checks state=0 after reset.
- Encoding and outputs per state:
  - 0 FETCH: MemRead, IRWrite, PCWrite, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=00, PCSource=00. Next: DECODE.
  - 1 DECODE: ALUSrcA=0, ALUSrcB=11, ALUop=00 (branch target into ALUOut). Next by op:
    - lw/sw -> MEM_ADDR; R -> R_EXEC; beq/bne -> BRANCH; j -> JUMP; jal -> JAL; addi/slti -> I_EXEC; lui -> LUI_WB.
    - Any other op: illegal=1, next FETCH, or HALT if ILLEGAL_TRAP=1.
  - 2 MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUop=00. Next: MEM_READ (lw) or MEM_WRITE (sw).
  - 3 MEM_READ: MemRead, IorD=1. Next: MEM_WB.
  - 4 MEM_WB: RegWrite, RegDst=00, MemToReg=01. Next: FETCH.
  - 5 MEM_WRITE: MemWrite, IorD=1. Next: FETCH.
  - 6 R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUop=10. Next: R_WB.
  - 7 R_WB: RegWrite, RegDst=01, MemToReg=00. Next: FETCH.
  - 8 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUop=01, PCSource=01, PCWriteCond=beq, PCWriteCondNe=bne. Next: FETCH.
  - 9 JUMP: PCWrite, PCSource=10. Next: FETCH.
  - 10 JAL: PCWrite, PCSource=10, RegWrite, RegDst=10, MemToReg=10 (PC already holds PC+4). Next: FETCH.
  - 11 I_EXEC: ALUSrcA=1, ALUSrcB=10, ALUop=00 for addi, 11 for slti. Next: I_WB.
  - 12 I_WB: RegWrite, RegDst=00, MemToReg=00. Next: FETCH.
  - 13 LUI_WB: RegWrite, RegDst=00, MemToReg=11. Next: FETCH.
  - 14 HALT: all outputs 0. Holds until rst.
  - 15: unreachable; the default next state is FETCH.
- Cycle counts with no wait: lw 5; sw, R, addi, slti 4; beq, bne, j, jal, lui 3.
- PCWrite and PCWriteCond/Ne are never asserted in the same state.

Optional Feature:
MC_MEM_WAIT_EN:
- Defined: adds input mem_ready (1 bit).
  - FETCH, MEM_READ and MEM_WRITE hold their state while mem_ready=0.
  - MemRead/MemWrite and IorD stay asserted during the hold; PCWrite and IRWrite are gated by mem_ready.
  - A state advances in the cycle mem_ready=1.
- Undefined: port absent; fixed one-cycle memory as above.

Decomposition:
- Shared package: state encodings (S_FETCH..S_HALT), opcode constants (OP_R=000000, OP_LW=100011, OP_SW=101011, OP_BEQ=000100, OP_BNE=000101, OP_J=000010, OP_JAL=000011, OP_ADDI=001000, OP_SLTI=001010, OP_LUI=001111), ALUop/PCSource/RegDst/MemToReg codes.
- Optional sub-module mc_op_dispatch: combinational op -> next state from DECODE, plus illegal.

Test Plan:
- rst high 2 cycles, op=0 -> state=0, MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=01.
- op=100011 (lw) -> states 0,1,2,3,4,0; MEM_WB has RegWrite=1, MemToReg=01, RegDst=00.
- op=000101 (bne) -> states 0,1,8; in 8: PCWriteCondNe=1, PCWriteCond=0, ALUop=01, PCSource=01.
- op=000011 (jal) -> state 10: PCWrite=1, RegWrite=1, RegDst=10, MemToReg=10, PCSource=10; then FETCH.
- op=111111 -> illegal=1 for exactly one cycle in DECODE. Then FETCH with ILLEGAL_TRAP=0; HALT held with ILLEGAL_TRAP=1 until rst.
- With MC_MEM_WAIT_EN, sw with mem_ready low 3 cycles in MEM_WRITE -> MemWrite held 4 cycles, then FETCH. Also assert rst in R_EXEC -> next state FETCH.
